// File: rtl/run_det_pkg.sv
// Shared definitions for the run detector.
//
// Contents:
//   run_state_e  - FSM state encoding exposed on state_o (IDLE=0, RUN0=1, RUN1=2)
//   MODE_*       - values of mode_i selecting which run polarities are reported
//   qualify()    - true when a run of the given state/length counts as detected
package run_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN0 = 2'd1,
        ST_RUN1 = 2'd2
    } run_state_e;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // A run qualifies once its length has reached run_len and the mode
    // enables the run's polarity. IDLE never qualifies.
    function automatic logic qualify(
        input run_state_e  st,
        input int unsigned cnt,
        input int unsigned run_len,
        input logic [1:0]  mode
    );
        logic pol_en;
        pol_en = 1'b0;
        case (st)
            ST_RUN0: pol_en = mode[0];
            ST_RUN1: pol_en = mode[1];
            default: pol_en = 1'b0;
        endcase
        return (cnt == run_len) && pol_en;
    endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk_i  in   clock, rising edge
//   clr_i  in   synchronous clear to zero; takes priority over inc_i
//   inc_i  in   add one this cycle (ignored once the count is all-ones)
//   cnt_o  out  registered count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_detector.sv
// run_detector: tracks runs of equal bits on a qualified serial stream and
// flags runs of RUN_LEN or more bits of an enabled polarity.
//
// Ports:
//   clk_i      in   clock, rising edge
//   res_i      in   synchronous active-high reset, overrides all other inputs
//   w_i        in   serial data bit
//   valid_i    in   w_i is sampled only when high
//   mode_i     in   00 off, 01 report 0-runs, 10 report 1-runs, 11 both
//   clr_i      in   synchronous clear of hit_cnt_o only
//   z_o        out  current run qualifies under mode_i (level)
//   hit_o      out  one-cycle pulse when a run first reaches RUN_LEN and qualifies
//   run_bit_o  out  polarity of the current run (1 only in RUN1)
//   run_cnt_o  out  current run length, saturating at RUN_LEN
//   state_o    out  FSM state (IDLE=0, RUN0=1, RUN1=2)
//   hit_cnt_o  out  tally of hits, saturating at all-ones
//
// Input handshake: valid_i qualifies w_i for one cycle; there is no ready,
// every valid bit is consumed at the rising edge where it is presented.
module run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter int HIT_W   = 8
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             w_i,
    input  logic             valid_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             z_o,
    output logic             hit_o,
    output logic             run_bit_o,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic [1:0]       state_o,
    output logic [HIT_W-1:0] hit_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(RUN_LEN - 1);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             z_q,     z_d;
    logic             hit_q,   hit_d;
    logic [CNT_W-1:0] cnt_inc;

    // Length of the current run extended by one bit, held at RUN_LEN.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = w_i ? ST_RUN1 : ST_RUN0;
                    cnt_d   = CNT_ONE;
                end
                ST_RUN0: begin
                    if (!w_i) begin
                        cnt_d = cnt_inc;
                    end else begin
                        state_d = ST_RUN1;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_RUN1: begin
                    if (w_i) begin
                        cnt_d = cnt_inc;
                    end else begin
                        state_d = ST_RUN0;
                        cnt_d   = CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // z follows the next state/count so a mode change is seen at the
        // next edge even without a valid bit.
        z_d = qualify(state_d, 32'(cnt_d), RUN_LEN, mode_i);

        // Only the step RUN_LEN-1 -> RUN_LEN fires; a run that was already
        // saturated when the mode enabled it never produces a hit.
        hit_d = valid_i && (cnt_q == CNT_PRE) && z_d;
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            hit_q   <= hit_d;
        end
    end

    // The tally counts on the same edge that raises hit_o, so hit_cnt_o
    // already includes a hit in the cycle hit_o is high. A clear on that
    // edge wins over the increment.
    sat_counter #(
        .W (HIT_W)
    ) u_hit_cnt (
        .clk_i (clk_i),
        .clr_i (res_i | clr_i),
        .inc_i (hit_d),
        .cnt_o (hit_cnt_o)
    );

    assign z_o       = z_q;
    assign hit_o     = hit_q;
    assign run_bit_o = (state_q == ST_RUN1);
    assign run_cnt_o = cnt_q;
    assign state_o   = state_q;

endmodule
